// File: rtl/fir_coef_loader_if.sv
// fir_coef_loader_if
//   Bundles the host tap-word stream and the coefficient-store write port of
//   fir_coef_loader.
//
//   Stream (host -> loader):  s_valid, s_data[BITS], s_last;  s_ready back
//   Row write (loader -> store): wr_en, wr_addr[$clog2(ROWS)], wr_data[BITS*(ORDER+1)]
//   Status (loader -> host):  load_busy, load_done, short_row
//   Optional (FIR_COEF_LOADER_CHECKSUM_EN): checksum[BITS], loader -> host
//
//   Modports: master = host/testbench side, slave = loader side.
interface fir_coef_loader_if #(
   parameter int BITS  = 16,
   parameter int ORDER = 4,
   parameter int ROWS  = 16
);
   localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int ROW_W = BITS * (ORDER + 1);

   logic             s_valid;
   logic             s_ready;
   logic [BITS-1:0]  s_data;
   logic             s_last;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [ROW_W-1:0] wr_data;
   logic             load_busy;
   logic             load_done;
   logic             short_row;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
   logic [BITS-1:0]  checksum;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, wr_en, wr_addr, wr_data, load_busy, load_done, short_row, checksum
   );
   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, wr_en, wr_addr, wr_data, load_busy, load_done, short_row, checksum
   );
`else
   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, wr_en, wr_addr, wr_data, load_busy, load_done, short_row
   );
   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, wr_en, wr_addr, wr_data, load_busy, load_done, short_row
   );
`endif
endinterface

// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//   Accepts a host stream of BITS-wide tap words (valid/ready), packs ORDER+1
//   taps per row and writes each full row into the coefficient store read by
//   the FIR controller. A row closes on tap ORDER or on s_last; taps missing
//   after an early s_last are written as zero and flagged with short_row.
//   A load ends on s_last or after row ROWS-1.
//
// Ports
//   dpu_clk  in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   bus      slave modport of fir_coef_loader_if:
//              s_valid/s_ready/s_data/s_last  host tap stream
//              wr_en/wr_addr/wr_data          one-cycle row write to the store
//              load_busy/load_done/short_row  load status
//
// Configuration
//   FIR_COEF_LOADER_CHECKSUM_EN  adds bus.checksum, mod-2^BITS sum of all
//                                accepted words of the current load.
module fir_coef_loader #(
   parameter int BITS  = 16,
   parameter int ORDER = 4,
   parameter int ROWS  = 16
) (
   input logic             dpu_clk,
   input logic             rst_n,
   fir_coef_loader_if.slave bus
);
   localparam int TAP_W = (ORDER > 0) ? $clog2(ORDER + 1) : 1;
   localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int ROW_W = BITS * (ORDER + 1);
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(ORDER);
   localparam logic [AW-1:0]    LAST_ROW = AW'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t           state_q;
   logic [TAP_W-1:0] tap_q;
   logic [AW-1:0]    row_q;
   logic [ROW_W-1:0] pack_q;
   logic             last_q;
   logic             short_q;
   logic             ready_q;
   logic             wr_en_q;
   logic [AW-1:0]    wr_addr_q;
   logic [ROW_W-1:0] wr_data_q;
   logic             busy_q;
   logic             done_q;
   logic             short_row_q;

   logic             xfer;
   logic             row_end;
   logic [ROW_W-1:0] pack_d;

   // ready_q is only high in IDLE/COLLECT, so a transfer implies one of those states
   assign xfer    = bus.s_valid & ready_q;
   assign row_end = bus.s_last | (tap_q == LAST_TAP);

   // Tap 0 starts from an all-zero row so that slots after an early s_last are padding
   always_comb begin
      pack_d = (tap_q == '0) ? '0 : pack_q;
      for (int k = 0; k <= ORDER; k++) begin
         if (tap_q == TAP_W'(k)) pack_d[BITS*k +: BITS] = bus.s_data;
      end
   end

   always_ff @(posedge dpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tap_q       <= '0;
         row_q       <= '0;
         pack_q      <= '0;
         last_q      <= 1'b0;
         short_q     <= 1'b0;
         ready_q     <= 1'b1;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         short_row_q <= 1'b0;
      end else begin
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;
         short_row_q <= 1'b0;
         case (state_q)
            IDLE, COLLECT: begin
               if (xfer) begin
                  busy_q <= 1'b1;
                  pack_q <= pack_d;
                  if (row_end) begin
                     state_q   <= WRITE;
                     ready_q   <= 1'b0;
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= row_q;
                     wr_data_q <= pack_d;
                     last_q    <= bus.s_last;
                     // s_last landing on the final tap is a normal end, not a short row
                     short_q   <= bus.s_last & (tap_q != LAST_TAP);
                     tap_q     <= '0;
                  end else begin
                     state_q <= COLLECT;
                     tap_q   <= tap_q + 1'b1;
                  end
               end
            end
            WRITE: begin
               if (last_q || (row_q == LAST_ROW)) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  short_row_q <= short_q;
               end else begin
                  state_q <= COLLECT;
                  row_q   <= row_q + 1'b1;
                  ready_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               row_q   <= '0;
               tap_q   <= '0;
               last_q  <= 1'b0;
               short_q <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
   logic [BITS-1:0] cksum_q;

   // First transfer of a load (taken in IDLE) restarts the sum
   always_ff @(posedge dpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         cksum_q <= '0;
      end else if (xfer) begin
         cksum_q <= (state_q == IDLE) ? bus.s_data : cksum_q + bus.s_data;
      end
   end

   assign bus.checksum = cksum_q;
`endif

   assign bus.s_ready   = ready_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.load_busy = busy_q;
   assign bus.load_done = done_q;
   assign bus.short_row = short_row_q;
endmodule

// File: tb/tb_fir_coef_loader.sv
module tb_fir_coef_loader;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fir_coef_loader_if #(.BITS(16), .ORDER(4), .ROWS(16)) bus ();

   fir_coef_loader #(.BITS(16), .ORDER(4), .ROWS(16)) dut (
      .dpu_clk (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Passive observers, sampled on the falling edge
   int wr_cnt    = 0;
   int done_cnt  = 0;
   int short_cnt = 0;
   int viol      = 0;
   int xfer_cnt  = 0;
   logic [79:0] wr_log[$];
   logic [3:0]  addr_log[$];

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         wr_cnt++;
         wr_log.push_back(bus.wr_data);
         addr_log.push_back(bus.wr_addr);
      end
      if (bus.load_done === 1'b1) begin
         done_cnt++;
         if (bus.short_row === 1'b1) short_cnt++;
      end
      // s_ready must be low exactly in the write and done cycles
      if (rst_n === 1'b1 && (bus.s_ready !== !(bus.wr_en || bus.load_done))) viol++;
      if (rst_n === 1'b1 && bus.s_valid === 1'b1 && bus.s_ready === 1'b1) xfer_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] exp_row(input int r);
      logic [79:0] v;
      v = '0;
      for (int k = 0; k < 5; k++) v[16*k +: 16] = 16'(5*r + k + 1);
      return v;
   endfunction

   // Present one word and hold it until accepted; returns #1 after the accepting edge
   task automatic send(input logic [15:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      for (int n = 0; n < 50 && !ok; n++) begin
         if (bus.s_ready === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      if (!ok) check("send_timeout", {79'b0, bus.s_ready}, 80'd1);
   endtask

   task automatic idle_cycle();
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_full(input bit gap, input string tag);
      int base_wr, base_done, base_short, base_x;
      base_wr    = wr_cnt;
      base_done  = done_cnt;
      base_short = short_cnt;
      base_x     = xfer_cnt;
      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < 5; k++) begin
            send(16'(5*r + k + 1), 1'b0);
            if (k == 4) begin
               check({tag, "_wr_en"},   {79'b0, bus.wr_en}, 80'd1);
               check({tag, "_wr_addr"}, {76'b0, bus.wr_addr}, 80'(r));
               check({tag, "_wr_data"}, bus.wr_data, exp_row(r));
               check({tag, "_rdy_wr"},  {79'b0, bus.s_ready}, 80'd0);
            end
            if (gap && !(r == 15 && k == 4)) idle_cycle();
         end
      end
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_done"},     {79'b0, bus.load_done}, 80'd1);
      check({tag, "_short"},    {79'b0, bus.short_row}, 80'd0);
      check({tag, "_busy_dn"},  {79'b0, bus.load_busy}, 80'd1);
      check({tag, "_rdy_dn"},   {79'b0, bus.s_ready}, 80'd0);
      @(posedge clk); #1;
      check({tag, "_busy_off"}, {79'b0, bus.load_busy}, 80'd0);
      check({tag, "_rdy_idle"}, {79'b0, bus.s_ready}, 80'd1);
      check({tag, "_hold_data"}, bus.wr_data, exp_row(15));
      check({tag, "_nwr"},      80'(wr_cnt - base_wr), 80'd16);
      for (int r = 0; r < 16; r++) begin
         check({tag, "_log_addr"}, {76'b0, addr_log[base_wr + r]}, 80'(r));
         check({tag, "_log_data"}, wr_log[base_wr + r], exp_row(r));
      end
      check({tag, "_ndone"},    80'(done_cnt - base_done), 80'd1);
      check({tag, "_nshort"},   80'(short_cnt - base_short), 80'd0);
      check({tag, "_nxfer"},    80'(xfer_cnt - base_x), 80'd80);
   endtask

   initial begin
      int base_wr;
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state
      check("rst_ready", {79'b0, bus.s_ready},   80'd1);
      check("rst_wr_en", {79'b0, bus.wr_en},     80'd0);
      check("rst_busy",  {79'b0, bus.load_busy}, 80'd0);
      check("rst_done",  {79'b0, bus.load_done}, 80'd0);
      check("rst_short", {79'b0, bus.short_row}, 80'd0);
      check("rst_addr",  {76'b0, bus.wr_addr},   80'd0);
      check("rst_data",  bus.wr_data,            80'd0);

      // Full 16-row load, back-to-back words then with a one-cycle gap between words
      run_full(1'b0, "full");
      run_full(1'b1, "gap");

      // Early end: three words, s_last on the third
      send(16'h0001, 1'b0);
      check("early_busy", {79'b0, bus.load_busy}, 80'd1);
      send(16'h0002, 1'b0);
      send(16'h0003, 1'b1);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      check("early_wr_en", {79'b0, bus.wr_en},   80'd1);
      check("early_addr",  {76'b0, bus.wr_addr}, 80'd0);
      check("early_data",  bus.wr_data, 80'h0000_0000_0003_0002_0001);
      @(posedge clk); #1;
      check("early_done",  {79'b0, bus.load_done}, 80'd1);
      check("early_short", {79'b0, bus.short_row}, 80'd1);
      check("early_wr_off", {79'b0, bus.wr_en},    80'd0);
      @(posedge clk); #1;
      check("early_idle",  {79'b0, bus.load_busy}, 80'd0);

      // Reset in the middle of row 2
      base_wr = wr_cnt;
      for (int i = 0; i < 13; i++) send(16'(i + 1), 1'b0);
      bus.s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", {79'b0, bus.s_ready},   80'd1);
      check("mid_rst_busy",  {79'b0, bus.load_busy}, 80'd0);
      check("mid_rst_wr_en", {79'b0, bus.wr_en},     80'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_nwr", 80'(wr_cnt - base_wr), 80'd2);

      // Next load starts at row 0; s_last on the final tap is a normal end
      send(16'h0010, 1'b0);
      send(16'h0011, 1'b0);
      send(16'h0012, 1'b0);
      send(16'h0013, 1'b0);
      send(16'h0014, 1'b1);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      check("post_rst_wr_en", {79'b0, bus.wr_en},   80'd1);
      check("post_rst_addr",  {76'b0, bus.wr_addr}, 80'd0);
      check("post_rst_data",  bus.wr_data, 80'h0014_0013_0012_0011_0010);
      @(posedge clk); #1;
      check("post_rst_done",  {79'b0, bus.load_done}, 80'd1);
      check("post_rst_short", {79'b0, bus.short_row}, 80'd0);
      @(posedge clk); #1;

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
      // Checksum wraps modulo 2^16 and restarts with each load
      send(16'hFFFF, 1'b0);
      send(16'h0002, 1'b1);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      @(posedge clk); #1;
      check("cksum_done", {79'b0, bus.load_done}, 80'd1);
      check("cksum_val",  {64'b0, bus.checksum},  80'h0001);
      @(posedge clk); #1;
      check("cksum_hold", {64'b0, bus.checksum},  80'h0001);
`endif

      check("ready_protocol", 80'(viol), 80'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
